riscv_next_redirect_arbiter: RTL and testbench
==============================================

# riscv_next_redirect_arbiter

Arbitrates next-PC redirect requests from the prefetch-stage (PM) strategy, the decode-stage (ID) strategy and execute-stage (EX) branch resolution into a single redirect to instruction fetch. Keeps a small in-order queue of outstanding predictions so that each EX resolution can be checked against what was predicted. Generates the correcting redirect and younger-stage flushes on a mispredict. Sits between the jump-predictor strategies and the IF stage, and is built only under `USE_JUMP_PREDICTOR`.

## Interface
- ADDR_WIDTH, 16, PC and target address width.
- QDEPTH, 4, number of prediction queue entries; a power of two, at least 2.
- CNT_WIDTH, 16, width of the mispredict counter.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_stall  in  1  pipeline stall; while high, every request input below is ignored.
- i_pm_inject  in  1  PM strategy requests a taken redirect.
- i_pm_pc  in  ADDR_WIDTH  PC of the instruction the PM strategy predicted.
- i_pm_inject_addr  in  ADDR_WIDTH  predicted target from the PM strategy.
- i_id_inject  in  1  ID strategy requests a taken redirect.
- i_id_pc  in  ADDR_WIDTH  PC of the instruction the ID strategy predicted.
- i_id_inject_addr  in  ADDR_WIDTH  predicted target from the ID strategy.
- i_ex_valid  in  1  a control-transfer instruction resolves in EX this cycle.
- i_ex_pc  in  ADDR_WIDTH  PC of the resolving instruction.
- i_ex_jump_branch  in  1  the resolving instruction was actually taken.
- i_ex_jump_addr  in  ADDR_WIDTH  actual target of the resolving instruction.
- o_redirect  out  1  IF must load o_redirect_addr this cycle.
- o_redirect_addr  out  ADDR_WIDTH  next fetch PC.
- o_flush_pm  out  1  flush the PM stage.
- o_flush_id  out  1  flush the ID stage.
- o_mispredict  out  1  single-cycle pulse on a detected mispredict.
- o_queue_full  out  1  prediction queue holds QDEPTH entries.
- o_mispredict_count  out  CNT_WIDTH  saturating count of mispredicts.

## Operation
- Queue entry = {pc, target}. Entries are in program order; head = oldest.
- Reset, or `!i_rst_n` asserted at any time mid-operation: queue empty, pointers 0, counter 0. All outputs read 0 while reset is active.
- EX check, evaluated when `i_ex_valid && !i_stall`:
  - hit = queue non-empty and head.pc == i_ex_pc.
  - On a hit the head is popped. The instruction was predicted taken to head.target.
  - On a miss nothing is popped. The instruction was predicted not-taken.
  - Correct address = i_ex_jump_branch ? i_ex_jump_addr : i_ex_pc + 4, computed modulo 2^ADDR_WIDTH.
  - Mispredict when:
    - hit and (!taken or target != i_ex_jump_addr), or
    - miss and taken.
- Priority: EX mispredict > ID > PM. Exactly one source drives o_redirect in any cycle.
- EX mispredict:
  - o_redirect=1 with the correct address; o_flush_pm=1; o_flush_id=1; o_mispredict=1.
  - The entire queue is cleared, overriding any push or pop in that cycle.
  - The counter increments and saturates at all-ones.
- ID inject (no mispredict, `!i_stall`):
  - If the queue is non-empty and tail.pc == i_id_pc, the PM strategy already predicted this instruction:
    - Same target: no redirect, no flush, no change to the queue.
    - Different target: overwrite tail.target, o_redirect=1 to i_id_inject_addr, o_flush_pm=1.
  - Otherwise, if the queue is not full, or a pop happens this cycle: push the entry, o_redirect=1, o_flush_pm=1.
  - If the queue is full with no pop: drop the request. No redirect; EX corrects later.
- PM inject: accepted only when there is no mispredict and no ID inject this cycle. Push rules are the same as ID's, except it never overwrites an entry and never raises a flush.
- A PM inject that loses to ID or EX is discarded, not retained.
- o_queue_full is registered and reflects the post-update occupancy.

## Timing
- o_redirect, o_redirect_addr, o_flush_* and o_mispredict are combinational from the inputs and the current queue state, with zero latency to IF.
- Queue, occupancy and counter update on the same rising edge. A redirect issued in cycle N is visible to the EX check in cycle N+1.
- Push and pop in the same cycle at full occupancy are allowed; occupancy is unchanged.
- Pointers wrap modulo QDEPTH.
- i_stall=1: no push, no pop, no counter change, and all request-derived outputs read 0.

## Test plan
- Reset, then PM inject pc=0x0100, target=0x0200 → o_redirect=1, addr=0x0200, no flush, occupancy 1. Then EX valid pc=0x0100, taken, 0x0200 → no mispredict, queue empty.
- Queue empty; EX pc=0x0040, taken, 0x0080 → o_redirect addr=0x0080, both flushes, o_mispredict=1, count=1.
- Head {0x0100, 0x0200}; EX pc=0x0100, not taken → redirect 0x0104, queue cleared, count increments. Repeat with ADDR_WIDTH=16 and pc=0xFFFC → redirect 0x0000.
- Tail {0x0300, 0x0400}. ID inject pc=0x0300, addr=0x0500 → tail.target becomes 0x0500, redirect 0x0500, o_flush_pm=1. Same with addr=0x0400 → no redirect.
- Fill queue with 4 PM injects → o_queue_full=1.
  - 5th PM inject → no redirect, queue unchanged.
  - EX hit on the head plus an ID inject in the same cycle → pop and push both occur; full stays 1.
- Simultaneous EX mispredict, ID inject and PM inject → only the EX redirect appears and the queue is empty. Drive the counter to 0xFFFF → it stays at 0xFFFF. Assert i_rst_n low mid-sequence → all outputs 0 and the queue empty immediately.

Source files
------------

// File: rtl/riscv_next_redirect_arbiter.sv
// Purpose: merges PM/ID next-PC predictions and EX resolution into one IF redirect; tracks outstanding predictions.
// Latency: redirect, flush and mispredict outputs are combinational (zero cycles); queue, full flag and counter update on the next edge.
// Backpressure: i_stall freezes all state and masks every request; predictions arriving at a full queue with no pop are dropped.
module riscv_next_redirect_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int QDEPTH     = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stall,
    input  logic                  i_pm_inject,
    input  logic [ADDR_WIDTH-1:0] i_pm_pc,
    input  logic [ADDR_WIDTH-1:0] i_pm_inject_addr,
    input  logic                  i_id_inject,
    input  logic [ADDR_WIDTH-1:0] i_id_pc,
    input  logic [ADDR_WIDTH-1:0] i_id_inject_addr,
    input  logic                  i_ex_valid,
    input  logic [ADDR_WIDTH-1:0] i_ex_pc,
    input  logic                  i_ex_jump_branch,
    input  logic [ADDR_WIDTH-1:0] i_ex_jump_addr,
    output logic                  o_redirect,
    output logic [ADDR_WIDTH-1:0] o_redirect_addr,
    output logic                  o_flush_pm,
    output logic                  o_flush_id,
    output logic                  o_mispredict,
    output logic                  o_queue_full,
    output logic [CNT_WIDTH-1:0]  o_mispredict_count
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
        addr_t pc;
        addr_t target;
    } entry_t;

    // Prediction queue: entries in program order, head = oldest outstanding prediction.
    entry_t             queue_mem [QDEPTH];
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;      // next free slot
    logic [PTR_W-1:0]   last_ptr;      // youngest valid entry
    logic [OCC_W-1:0]   occupancy;
    logic [OCC_W-1:0]   next_occupancy;
    logic               queue_full_q;
    logic [CNT_WIDTH-1:0] mispredict_cnt_q;

    entry_t head_entry;
    entry_t tail_entry;

    logic   active;
    logic   q_empty;
    logic   q_full;

    logic   ex_check;
    logic   ex_hit;
    logic   ex_mispredict;
    logic   ex_pop;
    addr_t  ex_correct_addr;

    logic   id_req;
    logic   id_tail_match;
    logic   id_overwrite;
    logic   id_push;

    logic   pm_req;
    logic   pm_tail_match;
    logic   pm_push;

    logic   do_push;
    entry_t push_entry;

    assign last_ptr   = tail_ptr - PTR_W'(1);
    assign head_entry = queue_mem[head_ptr];
    assign tail_entry = queue_mem[last_ptr];
    assign q_empty    = (occupancy == '0);
    assign q_full     = (occupancy == OCC_W'(QDEPTH));

    // Requests only count outside reset and stall; this also forces every
    // combinational output to 0 while reset is held.
    assign active = i_rst_n && !i_stall;

    // EX resolution: a hit means the head entry predicted this instruction taken.
    always_comb begin
        ex_check        = active && i_ex_valid;
        ex_hit          = ex_check && !q_empty && (head_entry.pc == i_ex_pc);
        ex_correct_addr = i_ex_jump_branch ? i_ex_jump_addr : (i_ex_pc + addr_t'(4));
        ex_mispredict   = 1'b0;
        if (ex_check) begin
            if (ex_hit) begin
                ex_mispredict = !i_ex_jump_branch || (head_entry.target != i_ex_jump_addr);
            end else begin
                ex_mispredict = i_ex_jump_branch;
            end
        end
        // On a mispredict the whole queue is discarded, so a pop is irrelevant.
        ex_pop = ex_hit && !ex_mispredict;
    end

    // ID strategy: refine the youngest PM prediction for the same PC, else push a new one.
    always_comb begin
        id_req        = active && i_id_inject && !ex_mispredict;
        id_tail_match = !q_empty && (tail_entry.pc == i_id_pc);
        id_overwrite  = id_req && id_tail_match && (tail_entry.target != i_id_inject_addr);
        id_push       = id_req && !id_tail_match && (!q_full || ex_pop);
    end

    // PM strategy: lowest priority; any ID request in the same cycle discards it.
    always_comb begin
        pm_req        = active && i_pm_inject && !ex_mispredict && !i_id_inject;
        pm_tail_match = !q_empty && (tail_entry.pc == i_pm_pc);
        pm_push       = pm_req && !pm_tail_match && (!q_full || ex_pop);
    end

    // Select the single redirect source and its flushes by priority EX > ID > PM.
    always_comb begin
        o_redirect      = 1'b0;
        o_redirect_addr = '0;
        o_flush_pm      = 1'b0;
        o_flush_id      = 1'b0;
        o_mispredict    = 1'b0;
        if (ex_mispredict) begin
            o_redirect      = 1'b1;
            o_redirect_addr = ex_correct_addr;
            o_flush_pm      = 1'b1;
            o_flush_id      = 1'b1;
            o_mispredict    = 1'b1;
        end else if (id_overwrite || id_push) begin
            o_redirect      = 1'b1;
            o_redirect_addr = i_id_inject_addr;
            o_flush_pm      = 1'b1;
        end else if (pm_push) begin
            o_redirect      = 1'b1;
            o_redirect_addr = i_pm_inject_addr;
        end
    end

    // Push payload and the occupancy after this cycle's push/pop/clear.
    always_comb begin
        do_push    = id_push || pm_push;
        push_entry = id_push ? '{pc: i_id_pc, target: i_id_inject_addr}
                             : '{pc: i_pm_pc, target: i_pm_inject_addr};
        next_occupancy = occupancy;
        if (ex_mispredict) begin
            next_occupancy = '0;
        end else if (do_push && !ex_pop) begin
            next_occupancy = occupancy + OCC_W'(1);
        end else if (!do_push && ex_pop) begin
            next_occupancy = occupancy - OCC_W'(1);
        end
    end

    // Queue storage, pointers and occupancy; a mispredict empties the queue outright.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_ptr     <= '0;
            tail_ptr     <= '0;
            occupancy    <= '0;
            queue_full_q <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                queue_mem[i] <= '0;
            end
        end else begin
            occupancy    <= next_occupancy;
            queue_full_q <= (next_occupancy == OCC_W'(QDEPTH));
            if (ex_mispredict) begin
                head_ptr <= '0;
                tail_ptr <= '0;
            end else begin
                if (ex_pop) begin
                    head_ptr <= head_ptr + PTR_W'(1);
                end
                if (do_push) begin
                    queue_mem[tail_ptr] <= push_entry;
                    tail_ptr            <= tail_ptr + PTR_W'(1);
                end else if (id_overwrite) begin
                    queue_mem[last_ptr].target <= i_id_inject_addr;
                end
            end
        end
    end

    // Saturating mispredict counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mispredict_cnt_q <= '0;
        end else if (ex_mispredict && (mispredict_cnt_q != '1)) begin
            mispredict_cnt_q <= mispredict_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign o_queue_full       = queue_full_q;
    assign o_mispredict_count = mispredict_cnt_q;

endmodule

// File: tb/tb_riscv_next_redirect_arbiter.sv
module tb_riscv_next_redirect_arbiter;

    localparam int AW = 16;
    localparam int QD = 4;
    // Narrow counter so saturation is reachable in a few hundred cycles.
    localparam int CW = 8;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall;
    logic          pm_inject;
    logic [AW-1:0] pm_pc, pm_addr;
    logic          id_inject;
    logic [AW-1:0] id_pc, id_addr;
    logic          ex_valid;
    logic [AW-1:0] ex_pc;
    logic          ex_taken;
    logic [AW-1:0] ex_addr;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          flush_pm, flush_id, mispredict, queue_full;
    logic [CW-1:0] mis_count;

    int checks = 0;
    int errors = 0;
    int vec_no = 0;

    typedef struct {
        int            idx;
        logic          redir;
        logic [AW-1:0] addr;
        logic          fpm;
        logic          fid;
        logic          mis;
        logic          full;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    riscv_next_redirect_arbiter #(
        .ADDR_WIDTH (AW),
        .QDEPTH     (QD),
        .CNT_WIDTH  (CW)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_stall            (stall),
        .i_pm_inject        (pm_inject),
        .i_pm_pc            (pm_pc),
        .i_pm_inject_addr   (pm_addr),
        .i_id_inject        (id_inject),
        .i_id_pc            (id_pc),
        .i_id_inject_addr   (id_addr),
        .i_ex_valid         (ex_valid),
        .i_ex_pc            (ex_pc),
        .i_ex_jump_branch   (ex_taken),
        .i_ex_jump_addr     (ex_addr),
        .o_redirect         (redirect),
        .o_redirect_addr    (redirect_addr),
        .o_flush_pm         (flush_pm),
        .o_flush_id         (flush_id),
        .o_mispredict       (mispredict),
        .o_queue_full       (queue_full),
        .o_mispredict_count (mis_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, req);
        end
    endtask

    // Monitor: outputs are stable mid-cycle; compare against the oldest pending expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("redirect",      e.idx, 32'(redirect),      32'(e.redir));
            chk("redirect_addr", e.idx, 32'(redirect_addr), 32'(e.addr));
            chk("flush_pm",      e.idx, 32'(flush_pm),      32'(e.fpm));
            chk("flush_id",      e.idx, 32'(flush_id),      32'(e.fid));
            chk("mispredict",    e.idx, 32'(mispredict),    32'(e.mis));
            chk("queue_full",    e.idx, 32'(queue_full),    32'(e.full));
            chk("mis_count",     e.idx, 32'(mis_count),     32'(e.cnt));
        end
    end

    task automatic idle();
        stall = 0; pm_inject = 0; id_inject = 0; ex_valid = 0; ex_taken = 0;
        pm_pc = '0; pm_addr = '0; id_pc = '0; id_addr = '0; ex_pc = '0; ex_addr = '0;
    endtask

    task automatic pm(input logic [AW-1:0] pc, input logic [AW-1:0] a);
        pm_inject = 1; pm_pc = pc; pm_addr = a;
    endtask

    task automatic id(input logic [AW-1:0] pc, input logic [AW-1:0] a);
        id_inject = 1; id_pc = pc; id_addr = a;
    endtask

    task automatic ex(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] a);
        ex_valid = 1; ex_pc = pc; ex_taken = tk; ex_addr = a;
    endtask

    // Queue the expectation for the inputs currently driven, then advance one cycle.
    // full/cnt are the registered values visible during this cycle.
    task automatic step(input logic r, input logic [AW-1:0] a, input logic fpm, input logic fid,
                        input logic mis, input logic full, input logic [CW-1:0] cnt);
        exp_t e;
        e.idx = vec_no; e.redir = r; e.addr = a; e.fpm = fpm; e.fid = fid;
        e.mis = mis; e.full = full; e.cnt = cnt;
        exp_q.push_back(e);
        vec_no++;
        @(posedge clk);
        #2;
        idle();
    endtask

    initial begin
        logic [CW-1:0] model_cnt;
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #2;

        // Reset held: requests ignored, everything reads 0.
        pm(16'h0100, 16'h0200);                 step(1'b0, 16'h0000, 0, 0, 0, 0, 8'd0);
        rst_n = 1;

        // PM predict then EX confirms.
        pm(16'h0100, 16'h0200);                 step(1'b1, 16'h0200, 0, 0, 0, 0, 8'd0);
        ex(16'h0100, 1, 16'h0200);              step(1'b0, 16'h0000, 0, 0, 0, 0, 8'd0);
        // Empty queue, taken branch: mispredict.
        ex(16'h0040, 1, 16'h0080);              step(1'b1, 16'h0080, 1, 1, 1, 0, 8'd0);
        // Predicted taken, actually not taken.
        pm(16'h0100, 16'h0200);                 step(1'b1, 16'h0200, 0, 0, 0, 0, 8'd1);
        ex(16'h0100, 0, 16'h0200);              step(1'b1, 16'h0104, 1, 1, 1, 0, 8'd1);
        // Fall-through wraps at 2^16.
        pm(16'hFFFC, 16'h1234);                 step(1'b1, 16'h1234, 0, 0, 0, 0, 8'd2);
        ex(16'hFFFC, 0, 16'h1234);              step(1'b1, 16'h0000, 1, 1, 1, 0, 8'd2);

        // ID overrides tail target, then a repeat with the same target is silent.
        pm(16'h0300, 16'h0400);                 step(1'b1, 16'h0400, 0, 0, 0, 0, 8'd3);
        id(16'h0300, 16'h0500);                 step(1'b1, 16'h0500, 1, 0, 0, 0, 8'd3);
        id(16'h0300, 16'h0500);                 step(1'b0, 16'h0000, 0, 0, 0, 0, 8'd3);
        ex(16'h0300, 1, 16'h0500);              step(1'b0, 16'h0000, 0, 0, 0, 0, 8'd3);
        pm(16'h0300, 16'h0400);                 step(1'b1, 16'h0400, 0, 0, 0, 0, 8'd3);
        id(16'h0300, 16'h0400);                 step(1'b0, 16'h0000, 0, 0, 0, 0, 8'd3);
        ex(16'h0300, 1, 16'h0400);              step(1'b0, 16'h0000, 0, 0, 0, 0, 8'd3);

        // Stall masks everything; the later EX miss proves nothing was pushed.
        stall = 1; pm(16'h0A00, 16'h0B00);
        ex(16'h0C00, 1, 16'h0D00);              step(1'b0, 16'h0000, 0, 0, 0, 0, 8'd3);

        // Fill the queue.
        pm(16'h1000, 16'h2000);                 step(1'b1, 16'h2000, 0, 0, 0, 0, 8'd3);
        pm(16'h1010, 16'h2010);                 step(1'b1, 16'h2010, 0, 0, 0, 0, 8'd3);
        pm(16'h1020, 16'h2020);                 step(1'b1, 16'h2020, 0, 0, 0, 0, 8'd3);
        pm(16'h1030, 16'h2030);                 step(1'b1, 16'h2030, 0, 0, 0, 0, 8'd3);
        // Full: fifth PM dropped.
        pm(16'h1040, 16'h2040);                 step(1'b0, 16'h0000, 0, 0, 0, 1, 8'd3);
        // Pop + ID push at full occupancy.
        ex(16'h1000, 1, 16'h2000);
        id(16'h1050, 16'h3050);                 step(1'b1, 16'h3050, 1, 0, 0, 1, 8'd3);
        step(1'b0, 16'h0000, 0, 0, 0, 1, 8'd3);
        ex(16'h1010, 1, 16'h2010);              step(1'b0, 16'h0000, 0, 0, 0, 1, 8'd3);

        // EX mispredict beats ID and PM and clears the queue.
        ex(16'h1020, 0, 16'h2020);
        id(16'h5000, 16'h6000);
        pm(16'h7000, 16'h8000);                 step(1'b1, 16'h1024, 1, 1, 1, 0, 8'd3);
        // Former head 0x1030 is gone, so a correct taken is now a mispredict.
        ex(16'h1030, 1, 16'h2030);              step(1'b1, 16'h2030, 1, 1, 1, 0, 8'd4);

        // ID wins over PM; the PM request is discarded.
        id(16'h0500, 16'h0600);
        pm(16'h0700, 16'h0800);                 step(1'b1, 16'h0600, 1, 0, 0, 0, 8'd5);
        ex(16'h0500, 1, 16'h0600);              step(1'b0, 16'h0000, 0, 0, 0, 0, 8'd5);
        ex(16'h0700, 1, 16'h0800);              step(1'b1, 16'h0800, 1, 1, 1, 0, 8'd5);

        // Drive the counter into saturation.
        model_cnt = 8'd6;
        for (int k = 0; k < 252; k++) begin
            ex(16'h0040, 1, 16'h0080);          step(1'b1, 16'h0080, 1, 1, 1, 0, model_cnt);
            if (model_cnt != CNT_MAX) model_cnt = model_cnt + 8'd1;
        end
        step(1'b0, 16'h0000, 0, 0, 0, 0, CNT_MAX);

        // Reset mid-sequence: immediate clear of outputs, counter and queue.
        pm(16'h0900, 16'h0A00);                 step(1'b1, 16'h0A00, 0, 0, 0, 0, CNT_MAX);
        rst_n = 0; pm(16'h0B00, 16'h0C00);      step(1'b0, 16'h0000, 0, 0, 0, 0, 8'd0);
        rst_n = 1;
        ex(16'h0900, 1, 16'h0A00);              step(1'b1, 16'h0A00, 1, 1, 1, 0, 8'd0);
        step(1'b0, 16'h0000, 0, 0, 0, 0, 8'd1);

        repeat (2) @(posedge clk);
        chk("pending_expectations", vec_no, 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=%0d required=%0d", vec_no, 0);
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
